tl_a_arbiter_2to1: RTL
======================

Name: tl_a_arbiter_2to1

Overview:
- Two-requester TileLink-UL arbiter that shares one A-channel master port, the port watched by the TL monitor/repeater checker.
- Performs round-robin selection between requesters, holds the grant for multi-beat Put messages, and tags each requester's source ID with the port index.
- Steers D-channel responses back to the originating requester by that tag.
- Sits between two TL masters (core-side) and the repeater/crossbar input.

Parameters:
- BEAT_BYTES_LG, 3, log2 of data-bus bytes (64-bit beats, 8-bit mask).
- SRC_W, 6, per-requester source width. Outbound source is SRC_W+1 bits.

Ports:
- clock  input  1  sole clock.
- reset_n  input  1  asynchronous assert, active-low reset.
- inN_a_valid / inN_a_ready  in/out  1  A handshake, N=0,1.
- inN_a_opcode / inN_a_param / inN_a_size  input  3 each  TL A fields.
- inN_a_source  input  6  requester source.
- inN_a_address  input  31  address.
- inN_a_mask  input  8  byte mask.
- inN_a_data  input  64  data.
- inN_a_corrupt  input  1  corrupt.
- out_a_valid / out_a_ready  out/in  1  merged A handshake.
- out_a_opcode / out_a_param / out_a_size  output  3 each  muxed fields.
- out_a_source  output  7  {grant index, inN_a_source}.
- out_a_address  output  31, out_a_mask  output  8, out_a_data  output  64, out_a_corrupt  output  1.
- out_d_valid / out_d_ready  in/out  1  D handshake from slave.
- out_d_opcode / out_d_param / out_d_size  input  3 each.
- out_d_source  input  7.
- out_d_data  input  64, out_d_denied / out_d_corrupt  input  1.
- inN_d_valid / inN_d_ready  out/in  1  per-requester D handshake.
- inN_d_opcode / param / size (3), source (6), data (64), denied / corrupt (1)  output  D fields, broadcast to both requesters.
- busy  output  1  high while a multi-beat A message is mid-burst.

Behaviour:
- State: `locked` (1b), `owner` (1b), `beats_left` (up to 8 bits), `prio` (1b, requester that wins a tie).
- Reset values: locked=0, owner=0, beats_left=0, prio=0. All valid/ready outputs are 0 during reset and the first cycle after it.
- Arbitration when unlocked is combinational in the same cycle:
  - grant = the requester whose valid is high.
  - If both are valid, grant = prio.
  - The granted request drives out_a_*. Only the granted requester sees inN_a_ready = out_a_ready; the other sees 0.
- Beat count: a message carries data if opcode ∈ {0 PutFull, 1 PutPartial}.
  - beats = (has_data && size > 3) ? 1 << (size − 3) : 1.
  - size is clamped to a maximum of 6 (8 beats). Larger sizes are treated as 8 beats.
- First-beat fire (out_a_valid & out_a_ready) with beats > 1:
  - locked ← 1, owner ← grant, beats_left ← beats − 1, busy = 1 from the next cycle.
- While locked:
  - grant = owner regardless of the other valid.
  - Each fire decrements beats_left. The fire with beats_left == 1 clears locked.
- Round-robin pointer: on the last beat of any message (single-beat fire, or locked fire with beats_left == 1), prio ← ~grant.
- Source tagging: out_a_source = {grant, inG_a_source}. No outstanding-transaction tracking; source uniqueness per requester is the requester's responsibility.
- D routing is purely combinational with zero latency:
  - route = out_d_source[6].
  - in{route}_d_valid = out_d_valid; the other inN_d_valid = 0.
  - out_d_ready = in{route}_d_ready.
  - inN_d_source = out_d_source[5:0].
- No valid depends on a ready on any path. out_a_valid = OR of the granted requester's valid only.
- Reset mid-burst: locked is cleared immediately and asynchronously. The slave is not notified; a partial burst is a system-level error.
- Requester withdrawing valid mid-burst is illegal per TL. The arbiter stays locked and waits; it does not time out.

Test Plan:
- Single requester: in0 Get (opcode 4, size 3, source 0x05) with out_a_ready=1 → out_a_source=0x05, fire in 1 cycle; D AccessAckData source 0x05 → in0_d_valid=1, in1_d_valid=0.
- Tie: both valid, single-beat Gets, prio=0 after reset → in0 wins cycle 1, in1 wins cycle 2, in0 wins cycle 3; out_a_source[6] sequence 0,1,0.
- Burst lock: in1 PutFull size 6 (8 beats) while in0 is continuously valid → 8 consecutive in1 fires, busy=1 for beats 2–8, then in0 granted and prio=0.
- Backpressure: out_a_ready toggling 1/0 during a 4-beat PutPartial (size 5) → exactly 4 fires, beats_left 3→2→1→0, grant never switches.
- D routing with stall: out_d_source=0x45 and in1_d_ready=0 → in1_d_valid=1, out_d_ready=0, in1_d_source=0x05; response held until in1_d_ready=1.
- Async reset mid-burst: reset_n low after beat 3 of 8, asserted without a clock edge → locked=0 and busy=0 immediately; after release, in0 wins a tie.

Source files
------------

// File: rtl/tl_a_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
// Module      : tl_a_arbiter_2to1_if
// Description : TileLink-UL A/D channel bundle. The master modport drives the
//               A channel and accepts D responses; the slave modport is the
//               mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface tl_a_arbiter_2to1_if #(
   parameter int BEAT_BYTES_LG = 3,
   parameter int SRC_W         = 6
);
   localparam int c_data_w = 8 << BEAT_BYTES_LG;
   localparam int c_mask_w = 1 << BEAT_BYTES_LG;

   // A channel
   logic                a_valid;
   logic                a_ready;
   logic [2:0]          a_opcode;
   logic [2:0]          a_param;
   logic [2:0]          a_size;
   logic [SRC_W-1:0]    a_source;
   logic [30:0]         a_address;
   logic [c_mask_w-1:0] a_mask;
   logic [c_data_w-1:0] a_data;
   logic                a_corrupt;

   // D channel
   logic                d_valid;
   logic                d_ready;
   logic [2:0]          d_opcode;
   logic [2:0]          d_param;
   logic [2:0]          d_size;
   logic [SRC_W-1:0]    d_source;
   logic [c_data_w-1:0] d_data;
   logic                d_denied;
   logic                d_corrupt;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source,
             a_address, a_mask, a_data, a_corrupt,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source,
             d_data, d_denied, d_corrupt,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source,
             a_address, a_mask, a_data, a_corrupt,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source,
             d_data, d_denied, d_corrupt,
      input  d_ready
   );
endinterface
`default_nettype wire

// File: rtl/tl_a_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tl_a_arbiter_2to1
// Description : Two-requester TileLink-UL A-channel arbiter. Round-robin
//               grant, grant held across multi-beat Put bursts, requester
//               index tagged into the MSB of the outbound source, and D
//               responses steered back by that tag.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_a_arbiter_2to1 #(
   parameter int BEAT_BYTES_LG = 3,
   parameter int SRC_W         = 6
) (
   input  logic                  clock,
   input  logic                  reset_n,
   tl_a_arbiter_2to1_if.slave    in0,
   tl_a_arbiter_2to1_if.slave    in1,
   tl_a_arbiter_2to1_if.master   out,
   output logic                  busy
);
   localparam logic [2:0] c_beat_lg  = 3'(BEAT_BYTES_LG);
   localparam logic [2:0] c_max_size = 3'd6;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_owner;
   logic       w_owner_nxt;
   logic [7:0] r_beats_left;
   logic [7:0] w_beats_left_nxt;
   logic       r_prio;
   logic       w_prio_nxt;
   logic       r_en;

   logic       w_grant;
   logic       w_sel_valid;
   logic [2:0] w_sel_opcode;
   logic [2:0] w_sel_size;
   logic [2:0] w_size_clamp;
   logic       w_has_data;
   logic [7:0] w_beats;
   logic       w_fire;
   logic       w_route;

   // Hold all handshakes low until the first clock edge after reset release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_en <= 1'b0;
      else          r_en <= 1'b1;
   end

   // Locked bursts keep their owner; otherwise lone valid wins, ties go to prio
   assign w_grant = (r_state == S_BURST) ? r_owner :
                    ((in0.a_valid & in1.a_valid) ? r_prio : in1.a_valid);

   assign w_sel_valid  = w_grant ? in1.a_valid  : in0.a_valid;
   assign w_sel_opcode = w_grant ? in1.a_opcode : in0.a_opcode;
   assign w_sel_size   = w_grant ? in1.a_size   : in0.a_size;

   // Only PutFull/PutPartial carry data; sizes above 64 bytes count as 8 beats
   assign w_has_data   = (w_sel_opcode == 3'd0) | (w_sel_opcode == 3'd1);
   assign w_size_clamp = (w_sel_size > c_max_size) ? c_max_size : w_sel_size;
   assign w_beats      = (w_has_data && (w_size_clamp > c_beat_lg)) ?
                         (8'd1 << (w_size_clamp - c_beat_lg)) : 8'd1;

   assign out.a_valid  = r_en & w_sel_valid;
   assign w_fire       = out.a_valid & out.a_ready;

   assign out.a_opcode  = w_sel_opcode;
   assign out.a_param   = w_grant ? in1.a_param   : in0.a_param;
   assign out.a_size    = w_sel_size;
   assign out.a_source  = {w_grant, (w_grant ? in1.a_source : in0.a_source)};
   assign out.a_address = w_grant ? in1.a_address : in0.a_address;
   assign out.a_mask    = w_grant ? in1.a_mask    : in0.a_mask;
   assign out.a_data    = w_grant ? in1.a_data    : in0.a_data;
   assign out.a_corrupt = w_grant ? in1.a_corrupt : in0.a_corrupt;

   assign in0.a_ready  = r_en & ~w_grant & out.a_ready;
   assign in1.a_ready  = r_en &  w_grant & out.a_ready;

   assign busy = (r_state == S_BURST);

   // Burst lock / beat counter / round-robin pointer next-state logic
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_beats_left_nxt = r_beats_left;
      w_prio_nxt       = r_prio;
      case (r_state)
         S_IDLE: begin
            if (w_fire) begin
               if (w_beats > 8'd1) begin
                  w_state_nxt      = S_BURST;
                  w_owner_nxt      = w_grant;
                  w_beats_left_nxt = w_beats - 8'd1;
               end else begin
                  w_prio_nxt = ~w_grant;
               end
            end
         end
         S_BURST: begin
            if (w_fire) begin
               w_beats_left_nxt = r_beats_left - 8'd1;
               if (r_beats_left == 8'd1) begin
                  w_state_nxt = S_IDLE;
                  w_prio_nxt  = ~w_grant;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Arbiter state register; reset drops any burst lock immediately
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_beats_left <= 8'd0;
         r_prio       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_beats_left <= w_beats_left_nxt;
         r_prio       <= w_prio_nxt;
      end
   end

   // D responses return to the requester named by the source tag MSB
   assign w_route = out.d_source[SRC_W];

   assign in0.d_valid = r_en & out.d_valid & ~w_route;
   assign in1.d_valid = r_en & out.d_valid &  w_route;
   assign out.d_ready = r_en & (w_route ? in1.d_ready : in0.d_ready);

   assign in0.d_opcode  = out.d_opcode;
   assign in0.d_param   = out.d_param;
   assign in0.d_size    = out.d_size;
   assign in0.d_source  = out.d_source[SRC_W-1:0];
   assign in0.d_data    = out.d_data;
   assign in0.d_denied  = out.d_denied;
   assign in0.d_corrupt = out.d_corrupt;

   assign in1.d_opcode  = out.d_opcode;
   assign in1.d_param   = out.d_param;
   assign in1.d_size    = out.d_size;
   assign in1.d_source  = out.d_source[SRC_W-1:0];
   assign in1.d_data    = out.d_data;
   assign in1.d_denied  = out.d_denied;
   assign in1.d_corrupt = out.d_corrupt;
endmodule
`default_nettype wire
